// File: rtl/multi_debouncer_if.sv
// Button-conditioner bus: raw inputs in, debounced levels and event pulses out.
// Combinational wiring only; no flow control.
interface multi_debouncer_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] noisy_in;
  logic [N_CH-1:0] clean_level;
  logic [N_CH-1:0] clean_pulse;
  logic            any_pulse;

  modport master (
    output noisy_in,
    input  clean_level,
    input  clean_pulse,
    input  any_pulse
  );

  modport slave (
    input  noisy_in,
    output clean_level,
    output clean_pulse,
    output any_pulse
  );
endinterface

// File: rtl/multi_debouncer.sv
// N-channel synchroniser + stability filter + edge-event generator for push buttons.
// Latency STABLE_CNT+1 edges from input sample to level/pulse; no backpressure, outputs registered.
module multi_debouncer #(
  parameter int N_CH       = 4,
  parameter int STABLE_CNT = 50000,
  parameter int CNT_W      = 16,
  parameter int PULSE_MODE = 0
) (
  input  logic         clk,
  input  logic         rst,
  multi_debouncer_if.slave dbnc
);

  localparam logic [CNT_W-1:0] LP_TERM = CNT_W'(STABLE_CNT - 1);

  logic [N_CH-1:0]  r_sync0;
  logic [N_CH-1:0]  r_sync1;
  logic [N_CH-1:0]  r_level;
  logic [N_CH-1:0]  r_pulse;
  logic             r_any;
  logic [CNT_W-1:0] r_cnt [N_CH];

  logic [N_CH-1:0]  w_event;
  logic [N_CH-1:0]  w_level_nxt;
  logic [N_CH-1:0]  w_pulse_nxt;
  logic [CNT_W-1:0] w_cnt_nxt [N_CH];

  // Event polarity is judged on the value being accepted as the new level.
  always_comb begin
    case (PULSE_MODE)
      1:       w_event = ~r_sync1;
      2:       w_event = '1;
      default: w_event = r_sync1;
    endcase
  end

  always_comb begin
    w_level_nxt = r_level;
    w_pulse_nxt = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_cnt_nxt[i] = '0;
      if (r_sync1[i] != r_level[i]) begin
        if (r_cnt[i] == LP_TERM) begin
          w_level_nxt[i] = r_sync1[i];
          w_pulse_nxt[i] = w_event[i];
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync0 <= '0;
      r_sync1 <= '0;
      r_level <= '0;
      r_pulse <= '0;
      r_any   <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync0 <= dbnc.noisy_in;
      r_sync1 <= r_sync0;
      r_level <= w_level_nxt;
      r_pulse <= w_pulse_nxt;
      r_any   <= |w_pulse_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign dbnc.clean_level = r_level;
  assign dbnc.clean_pulse = r_pulse;
  assign dbnc.any_pulse   = r_any;

endmodule

// File: doc/multi_debouncer.md
Name: multi_debouncer

Overview:
Parametrised N-channel push-button conditioner that replaces the single-channel synchroniser/edge-detect stage. Each channel has a 2-flop synchroniser, a stability counter and a debounced level register. Each channel produces a single-cycle event pulse on rising, falling or both edges, selected by a parameter. The block sits between the raw floor/cabin call buttons and the elevator controller FSM; all outputs are registered.

Parameters:
N_CH, 4, number of independent input channels (>=1)
STABLE_CNT, 50000, consecutive cycles a synchronised input must differ from the debounced level before that level changes (>=1)
CNT_W, 16, stability counter width; must satisfy 2^CNT_W > STABLE_CNT-1
PULSE_MODE, 0, event selection: 0 = rising edge, 1 = falling edge, 2 = both edges; any other value behaves as 0

Ports:
clk  input  1  system clock; all state updates on posedge
rst  input  1  synchronous active-low reset, sampled on posedge clk
noisy_in  input  N_CH  raw asynchronous button inputs, bit i = channel i
clean_level  output  N_CH  debounced level per channel
clean_pulse  output  N_CH  one-cycle event pulse per channel, per PULSE_MODE
any_pulse  output  1  registered OR of the next-state clean_pulse bits; high in the same cycle as any clean_pulse bit

Behaviour:
- Clocking and reset:
  - Single clock.
  - Reset is synchronous and active-low: on a posedge clk with rst==0, clear every sync flop, counter, clean_level, clean_pulse and any_pulse to 0.
  - No asynchronous reset path.
  - Reset overrides all other activity, including a counter at its terminal value.
- Synchroniser, per channel i:
  - sync0[i] <= noisy_in[i]
  - sync1[i] <= sync0[i]
  - Only sync1 feeds the filter.
- Stability filter, per channel, evaluated every non-reset edge:
  - sync1 == clean_level: cnt <= 0; clean_pulse <= 0.
  - sync1 != clean_level and cnt == STABLE_CNT-1: clean_level <= sync1; cnt <= 0; clean_pulse <= event, where event = 1 if (PULSE_MODE 0 and sync1==1), (PULSE_MODE 1 and sync1==0), or PULSE_MODE 2; otherwise 0.
  - Otherwise (mismatch, not terminal): cnt <= cnt+1; clean_pulse <= 0.
- Glitch rejection: any cycle in which sync1 matches clean_level restarts the count from 0. A bounce shorter than STABLE_CNT cycles produces no level change and no pulse.
- Latency:
  - If noisy_in[i] changes and is sampled at edge k and stays constant, clean_level[i] and clean_pulse[i] update at edge k+1+STABLE_CNT.
  - clean_pulse is high for exactly one cycle per accepted transition.
  - Holding the input produces no further pulses, i.e. no auto-repeat.
- any_pulse: registered alongside clean_pulse from the same next-state values, so it is cycle-aligned with clean_pulse.
- Channel independence: channels share no state. Simultaneous transitions on several channels produce simultaneous pulses in the same cycle.
- No counter wrap: cnt never exceeds STABLE_CNT-1.
- Reset mid-operation:
  - A partially counted transition is discarded.
  - An input already high at reset release is treated as a new rising transition. With the first edge at rst==1 numbered k, level and pulse (if selected) update at edge k+1+STABLE_CNT.
- No combinational path from any input to any output.

Test Plan:
(Bench configuration: N_CH=4, STABLE_CNT=4, CNT_W=3, PULSE_MODE=0 unless stated.)
- Reset: hold rst=0 for 3 cycles with noisy_in=4'hF -> all outputs 0 throughout. Release at edge k -> clean_level=4'hF at edge k+5; clean_pulse=4'hF and any_pulse=1 for exactly that one cycle.
- Clean press: ch0 0->1 sampled at edge k -> clean_level[0]=1 and clean_pulse[0]=1 at edge k+5. Pulse low at edge k+6. No further pulses while held for 100 cycles.
- Bounce: ch1 toggles 1,0,1,1,1,0 on consecutive cycles, then stays 0 -> clean_level[1] stays 0 and no pulse. Then 1 for 3 cycles and back to 0 -> still no change. Then 1 held -> level rises 5 edges after the final 0->1 sample.
- PULSE_MODE=1 and =2: press and release ch2 with 10-cycle gaps -> mode 1: pulse only on release. Mode 2: pulses on both press and release. clean_level follows in both modes.
- Simultaneous channels: ch0 and ch3 rise at the same edge, ch1 falls 2 cycles later -> ch0 and ch3 pulses coincide with any_pulse=1. In mode 0 there is no pulse for ch1, but clean_level[1] drops at its own edge+5.
- Reset mid-count: ch2 high for 3 cycles, then rst=0 for 1 cycle while input stays high -> no pulse before reset. Level rises 5 edges after the first edge with rst==1.
